// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state type, access-size codes, port indices and the alignment helper.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

  localparam logic [1:0] SzB       = 2'b00;
  localparam logic [1:0] SzH       = 2'b01;
  localparam logic [1:0] SzW       = 2'b10;
  localparam logic [1:0] SzIllegal = 2'b11;

  localparam logic Port0 = 1'b0;
  localparam logic Port1 = 1'b1;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SzH) && lo[0]) || ((size == SzW) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering between a right-aligned requester view and a 32-bit memory word.
// Produces byte enables, replicated store data and the extended load result.
module dm_lane
  import dm_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0;
    rdata_ext = 32'h0;
    rd_byte   = mem_rdata[{lo, 3'b000} +: 8];
    rd_half   = lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size)
      SzB: begin
        be        = 4'b0001 << lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign & rd_byte[7]}}, rd_byte};
      end
      SzH: begin
        be        = lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign & rd_half[15]}}, rd_half};
      end
      SzW: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter sharing a synchronous-read word RAM; one transaction in flight,
// IDLE -> ISSUE -> RESP, with a one-cycle ack carrying error and extended load data.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic              p0_sign,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic              p1_sign,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  state_e state_q, state_d;
  logic   last_grant_q;

  logic              sel_q, we_q, sign_q, err_q;
  logic [1:0]        size_q, lo_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;

  logic        any_req, win, w_we, w_sign, err_d;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  logic        issue, resp;

  assign any_req = p0_req | p1_req;

  always_comb begin
    if (p0_req && p1_req) begin
      win = FIXED_PRIO ? Port0 : ~last_grant_q;
    end else begin
      win = p0_req ? Port0 : Port1;
    end
    w_we    = (win == Port1) ? p1_we    : p0_we;
    w_size  = (win == Port1) ? p1_size  : p0_size;
    w_sign  = (win == Port1) ? p1_sign  : p0_sign;
    w_addr  = (win == Port1) ? p1_addr  : p0_addr;
    w_wdata = (win == Port1) ? p1_wdata : p0_wdata;
    err_d   = (w_size == SzIllegal) || misaligned(w_size, w_addr[1:0]) ||
              (|(w_addr >> (ADDR_W + 2)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= Port1;
    end else begin
      state_q <= state_d;
      if (state_q == StResp) last_grant_q <= sel_q;
    end
  end

  // Transaction fields are captured once in IDLE and held until the next IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q   <= Port0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SzB;
      lo_q    <= 2'b00;
      idx_q   <= '0;
      wdata_q <= 32'h0;
    end else if (state_q == StIdle && any_req) begin
      sel_q   <= win;
      we_q    <= w_we;
      sign_q  <= w_sign;
      err_q   <= err_d;
      size_q  <= w_size;
      lo_q    <= w_addr[1:0];
      idx_q   <= w_addr[ADDR_W+1:2];
      wdata_q <= w_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  dm_lane u_lane (
    .size      (size_q),
    .sign      (sign_q),
    .lo        (lo_q),
    .wdata     (wdata_q),
    .mem_rdata (mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  always_comb begin
    issue     = (state_q == StIssue) && !err_q;
    resp      = (state_q == StResp);
    busy      = (state_q != StIdle);
    mem_en    = issue;
    mem_we    = issue & we_q;
    mem_addr  = issue ? idx_q : '0;
    mem_be    = issue ? lane_be : 4'b0000;
    mem_wdata = issue ? lane_wdata : 32'h0;
    p0_ack    = resp && (sel_q == Port0);
    p1_ack    = resp && (sel_q == Port1);
    p0_err    = p0_ack & err_q;
    p1_err    = p1_ack & err_q;
    rdata     = (resp && !we_q && !err_q) ? lane_rdata : 32'h0;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a round-robin instance with a RAM model, plus a
// fixed-priority instance sharing the same request inputs for the tie scenario.
module tb_dm_arbiter;

  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        p0_req, p0_we, p0_sign, p1_req, p1_we, p1_sign;
  logic [1:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  logic          p0_ack, p0_err, p1_ack, p1_err, mem_en, mem_we, busy;
  logic [31:0]   rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata = 32'h0;

  logic          d1_p0_ack, d1_p0_err, d1_p1_ack, d1_p1_err, d1_mem_en, d1_mem_we, d1_busy;
  logic [31:0]   d1_rdata, d1_mem_wdata;
  logic [AW-1:0] d1_mem_addr;
  logic [3:0]    d1_mem_be;

  dm_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_sign(p0_sign),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_sign(p1_sign),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  dm_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b1)) dut_fixed (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_sign(p0_sign),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(d1_p0_ack), .p0_err(d1_p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_sign(p1_sign),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(d1_p1_ack), .p1_err(d1_p1_err),
    .rdata(d1_rdata), .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
    .mem_be(d1_mem_be), .mem_wdata(d1_mem_wdata), .mem_rdata(mem_rdata), .busy(d1_busy)
  );

  // RAM model with a backdoor preload port; counts every committed write.
  logic [31:0]   ram [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = 32'h0;
  int unsigned   wr_cnt = 0;

  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic drive(input bit port, input bit req, input bit we, input logic [1:0] size,
                       input bit sign, input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_req = req; p1_we = we; p1_size = size; p1_sign = sign;
      p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_size = size; p0_sign = sign;
      p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  logic          cap_we;
  logic [3:0]    cap_be;
  logic [AW-1:0] cap_addr;
  logic [31:0]   cap_wdata;
  int            cap_k, men_cnt;

  // Called in an IDLE cycle just after an edge; returns in the following IDLE cycle.
  task automatic txn(input string tag, input bit port, input bit we, input logic [1:0] size,
                     input bit sign, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input bit exp_err);
    int ack_k = 0;
    logic got_err = 1'b0, other = 1'b0;
    logic [31:0] got_rd = 32'h0;
    men_cnt = 0;
    cap_k   = 0;
    drive(port, 1'b1, we, size, sign, addr, wdata);
    for (int k = 1; k <= 8 && ack_k == 0; k++) begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        men_cnt++;
        cap_k = k; cap_we = mem_we; cap_be = mem_be; cap_addr = mem_addr; cap_wdata = mem_wdata;
      end
      if (port ? p1_ack : p0_ack) begin
        ack_k   = k;
        got_err = port ? p1_err : p0_err;
        got_rd  = rdata;
        other   = port ? p0_ack : p1_ack;
      end
    end
    drive(port, 1'b0, we, size, sign, addr, wdata);
    check({tag, "_acklat"}, 64'(ack_k), 64'd2);
    if (ack_k != 0) begin
      check({tag, "_err"}, {63'd0, got_err}, {63'd0, exp_err});
      check({tag, "_rdata"}, {32'd0, got_rd}, {32'd0, exp_rdata});
      check({tag, "_otherack"}, {63'd0, other}, 64'd0);
    end
    check({tag, "_mencnt"}, 64'(men_cnt), exp_err ? 64'd0 : 64'd1);
    if (!exp_err) check({tag, "_menlat"}, 64'(cap_k), 64'd1);
    @(posedge clk);
    #1;
  endtask

  int unsigned w0;

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    poke(12'd0, 32'h1234_5678);
    poke(12'd1, 32'h0000_0000);
    poke(12'd4095, 32'h0BAD_F00D);

    // Reset held with a pending request: everything stays quiet.
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_ctl", {41'd0, p0_ack, p1_ack, p0_err, p1_err, mem_en, mem_we, busy,
                      mem_be, mem_addr}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    reset = 1'b1;
    txn("post_rst_lw", 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0);

    // Byte store then signed/unsigned byte loads.
    txn("sb", 1'b0, 1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_00A5, 32'h0, 1'b0);
    check("sb_be", {60'd0, cap_be}, 64'h4);
    check("sb_wdata", {32'd0, cap_wdata}, 64'hA5A5_A5A5);
    check("sb_addr", 64'(cap_addr), 64'd1);
    check("sb_we", {63'd0, cap_we}, 64'd1);
    txn("lb", 1'b0, 1'b0, 2'b00, 1'b1, 32'h6, 32'h0, 32'hFFFF_FFA5, 1'b0);
    txn("lbu", 1'b0, 1'b0, 2'b00, 1'b0, 32'h6, 32'h0, 32'h0000_00A5, 1'b0);

    // Half loads on port 1.
    poke(12'd1, 32'h8001_7FFE);
    txn("lh6", 1'b1, 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'hFFFF_8001, 1'b0);
    check("lh6_be", {60'd0, cap_be}, 64'hC);
    txn("lh4", 1'b1, 1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 32'h0000_7FFE, 1'b0);
    txn("lhu6", 1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'h0000_8001, 1'b0);

    // Word store/load and top-of-range word.
    txn("sw", 1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0);
    check("sw_be", {60'd0, cap_be}, 64'hF);
    check("sw_ram", {32'd0, ram[2]}, 64'hDEAD_BEEF);
    txn("lw8", 1'b0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn("lw_top", 1'b0, 1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, 32'h0BAD_F00D, 1'b0);
    check("lw_top_addr", 64'(cap_addr), 64'hFFF);

    // Error cases: ack with err, no memory command, no write.
    w0 = wr_cnt;
    txn("err_mis", 1'b0, 1'b1, 2'b10, 1'b0, 32'h2, 32'hFFFF_FFFF, 32'h0, 1'b1);
    txn("err_rng", 1'b0, 1'b1, 2'b10, 1'b0, 32'h4000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    txn("err_sz", 1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    txn("err_lh1", 1'b1, 1'b0, 2'b01, 1'b1, 32'h1, 32'h0, 32'h0, 1'b1);
    check("err_wrcnt", 64'(wr_cnt), 64'(w0));
    check("err_ram0", {32'd0, ram[0]}, 64'h1234_5678);

    // Continuous tie from reset: RR alternates, fixed priority serves port 0 only.
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("tie_rr_k%0d", k), {62'd0, p1_ack, p0_ack},
            {62'd0, (k % 6) == 5, (k % 6) == 2});
      check($sformatf("tie_fx_k%0d", k), {62'd0, d1_p1_ack, d1_p0_ack},
            {62'd0, 1'b0, (k % 3) == 2});
      check($sformatf("tie_busy_k%0d", k), {63'd0, busy}, {63'd0, (k % 3) != 0});
      if ((k % 6) == 2) check($sformatf("tie_rd_k%0d", k), {32'd0, rdata}, 64'h1234_5678);
      if ((k % 6) == 5) check($sformatf("tie_rd_k%0d", k), {32'd0, rdata}, 64'hDEAD_BEEF);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset during ISSUE of a store: no ack and no later write.
    poke(12'd3, 32'h1111_1111);
    drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    check("mid_issue_men", {63'd0, mem_en}, 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    w0 = wr_cnt;
    p0_req = 1'b0;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) reset = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("mid_ack_k%0d", k), {62'd0, p1_ack, p0_ack}, 64'd0);
      check($sformatf("mid_men_k%0d", k), {63'd0, mem_en}, 64'd0);
      check($sformatf("mid_wr_k%0d", k), 64'(wr_cnt), 64'(w0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
